imm_gen_pipe: RTL

- Pipelined, parametrised successor to the core's combinational immediate extender.
- Sits between decode and execute. Accepts an instruction word plus format select over a valid/ready handshake and emits the sign/zero-extended immediate one cycle later.
- Generalised to XLEN 32/64. Adds CSR-zimm and shift-amount formats, a sideband tag, flush, and a 2-entry skid buffer so full throughput is kept under back-pressure.

---
 rtl/imm_gen_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate extender with valid/ready handshake and a 2-entry skid buffer.
// The instruction is decoded combinationally on the input side and registered, so
// there is no combinational path from any in_* port to any out_* port.
// Optional build macro: IMM_GEN_ILLEGAL_CHECK_EN enables the out_illegal flag and its
// storage; without it out_illegal is tied low.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [2:0] SrcI     = 3'b000;
  localparam logic [2:0] SrcS     = 3'b001;
  localparam logic [2:0] SrcB     = 3'b010;
  localparam logic [2:0] SrcJ     = 3'b011;
  localparam logic [2:0] SrcU     = 3'b100;
  localparam logic [2:0] SrcZimm  = 3'b101;
  localparam logic [2:0] SrcShamt = 3'b110;

  logic            s;
  logic [31:0]     val32;
  logic [XLEN-1:0] imm_c;

  // Opcode bits carry no immediate information.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  assign s = in_instr[31];

  // Build a 32-bit sign-extended value; zero-extended formats have bit 31 clear,
  // so one final signed widening to XLEN is correct for every format.
  always_comb begin
    val32 = '0;
    case (in_immsrc)
      SrcI:     val32 = {{20{s}}, in_instr[31:20]};
      SrcS:     val32 = {{20{s}}, in_instr[31:25], in_instr[11:7]};
      SrcB:     val32 = {{19{s}}, in_instr[31], in_instr[7], in_instr[30:25],
                         in_instr[11:8], 1'b0};
      SrcJ:     val32 = {{11{s}}, in_instr[31], in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
      SrcU:     val32 = {in_instr[31:12], 12'b0};
      SrcZimm:  val32 = {27'b0, in_instr[19:15]};
      SrcShamt: val32 = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
      default:  val32 = '0;
    endcase
  end

  assign imm_c = XLEN'($signed(val32));

  logic             or_valid_q, sk_valid_q;
  logic             or_valid_d, sk_valid_d;
  logic [XLEN-1:0]  or_imm_q, sk_imm_q;
  logic [TAG_W-1:0] or_tag_q, sk_tag_q;

  logic accept, drain, or_free, or_load_sk, or_load_new, sk_load;

  // in_ready depends only on a flop, never on out_ready.
  assign in_ready    = !sk_valid_q;
  assign accept      = in_valid && in_ready && !flush;
  assign drain       = or_valid_q && out_ready;
  assign or_free     = !or_valid_q || drain;
  // SK refills OR first; accept is impossible while SK is valid.
  assign or_load_sk  = !flush && or_free && sk_valid_q;
  assign or_load_new = accept && or_free && !sk_valid_q;
  assign sk_load     = accept && !or_free;

  // Next-state valid bits; flush overrides accept and drain.
  always_comb begin
    or_valid_d = or_valid_q;
    sk_valid_d = sk_valid_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else begin
      if (or_free) begin
        or_valid_d = sk_valid_q || accept;
      end
      if (or_load_sk) begin
        sk_valid_d = 1'b0;
      end else if (sk_load) begin
        sk_valid_d = 1'b1;
      end
    end
  end

  // Valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_valid_q <= 1'b0;
      sk_valid_q <= 1'b0;
    end else begin
      or_valid_q <= or_valid_d;
      sk_valid_q <= sk_valid_d;
    end
  end

  // Payload registers; OR only changes when it is free, keeping data stable under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_imm_q <= '0;
      or_tag_q <= '0;
      sk_imm_q <= '0;
      sk_tag_q <= '0;
    end else begin
      if (or_load_sk) begin
        or_imm_q <= sk_imm_q;
        or_tag_q <= sk_tag_q;
      end else if (or_load_new) begin
        or_imm_q <= imm_c;
        or_tag_q <= in_tag;
      end
      if (sk_load) begin
        sk_imm_q <= imm_c;
        sk_tag_q <= in_tag;
      end
    end
  end

  assign out_valid = or_valid_q;
  assign out_imm   = or_imm_q;
  assign out_tag   = or_tag_q;

`ifdef IMM_GEN_ILLEGAL_CHECK_EN
  logic ill_c, or_ill_q, sk_ill_q;

  assign ill_c = (in_immsrc == 3'b111) ||
                 ((in_immsrc == SrcShamt) && (XLEN == 32) && in_instr[25]);

  // Illegal flag follows its entry through SK exactly like the payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_ill_q <= 1'b0;
      sk_ill_q <= 1'b0;
    end else begin
      if (or_load_sk) begin
        or_ill_q <= sk_ill_q;
      end else if (or_load_new) begin
        or_ill_q <= ill_c;
      end
      if (sk_load) begin
        sk_ill_q <= ill_c;
      end
    end
  end

  assign out_illegal = or_ill_q;
`else
  assign out_illegal = 1'b0;
`endif

endmodule
